// File: rtl/acl_poll_ctrl_if.sv
// Byte-level SPI master handshake between the poll sequencer
// and the SPI core, plus the accelerometer slave select.
interface acl_poll_ctrl_if;
  logic       spi_ready;
  logic       spi_done_tick;
  logic [7:0] spi_rd_byte;
  logic       spi_start;
  logic [7:0] spi_wr_byte;
  logic       spi_ss_n;

  modport master (
    input  spi_ready,
    input  spi_done_tick,
    input  spi_rd_byte,
    output spi_start,
    output spi_wr_byte,
    output spi_ss_n
  );

  modport slave (
    output spi_ready,
    output spi_done_tick,
    output spi_rd_byte,
    input  spi_start,
    input  spi_wr_byte,
    input  spi_ss_n
  );
endinterface

// File: rtl/acl_poll_ctrl.sv
// ADXL362 sequencer: one POWER_CTL write, then periodic X/Y/Z
// burst reads presented as registers with a valid tick.
module acl_poll_ctrl #(
  parameter int unsigned PERIOD_CYCLES = 1_000_000,
  parameter int unsigned SS_GAP        = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  acl_poll_ctrl_if.master       spi,
  output logic [15:0]           x_data,
  output logic [15:0]           y_data,
  output logic [15:0]           z_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  init_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_SETUP,
    S_INIT_XFER,
    S_INIT_HOLD,
    S_WAIT,
    S_RD_SETUP,
    S_RD_XFER,
    S_RD_HOLD,
    S_UPDATE
  } state_t;

  localparam int unsigned CNT_MAX =
    (PERIOD_CYCLES > SS_GAP) ? PERIOD_CYCLES : SS_GAP;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_CYCLES - 1);
  localparam logic [2:0] INIT_LAST = 3'd2;
  localparam logic [2:0] RD_LAST   = 3'd7;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_pend;
  logic          r_init_done;
  logic [7:0]    r_shadow [0:5];
  logic [15:0]   r_x;
  logic [15:0]   r_y;
  logic [15:0]   r_z;

  logic          w_start;
  logic          w_ss_n;
  logic          w_busy;
  logic          w_dv;
  logic [7:0]    w_wr;
  logic          w_done;
  logic          w_gap_end;
  logic          w_per_end;
  logic          w_counting;
  logic          w_capture;
  logic          w_load;

  function automatic logic [7:0] init_byte(
    input logic [2:0] idx
  );
    case (idx)
      3'd0:    return 8'h0A;
      3'd1:    return 8'h2D;
      default: return 8'h02;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(
    input logic [2:0] idx
  );
    case (idx)
      3'd0:    return 8'h0B;
      3'd1:    return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  // A done tick only counts against our own outstanding start
  assign w_done    = spi.spi_done_tick && r_pend;
  assign w_gap_end = (r_cnt == GAP_LAST);
  assign w_per_end = (r_cnt == PER_LAST);

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_ss_n  = 1'b1;
    w_busy  = 1'b0;
    w_dv    = 1'b0;
    w_wr    = 8'h00;
    unique case (r_state)
      S_IDLE: begin
        if (en)
          w_next = r_init_done ? S_RD_SETUP
                               : S_INIT_SETUP;
      end
      S_INIT_SETUP, S_RD_SETUP: begin
        w_ss_n = 1'b0;
        w_busy = 1'b1;
        if (!en)
          w_next = S_IDLE;
        else if (w_gap_end)
          w_next = (r_state == S_INIT_SETUP) ? S_INIT_XFER
                                             : S_RD_XFER;
      end
      S_INIT_XFER: begin
        w_ss_n  = 1'b0;
        w_busy  = 1'b1;
        w_wr    = init_byte(r_idx);
        w_start = spi.spi_ready && !r_pend;
        if (w_done && r_idx == INIT_LAST)
          w_next = S_INIT_HOLD;
      end
      S_RD_XFER: begin
        w_ss_n  = 1'b0;
        w_busy  = 1'b1;
        w_wr    = rd_byte(r_idx);
        w_start = spi.spi_ready && !r_pend;
        if (w_done && r_idx == RD_LAST)
          w_next = S_RD_HOLD;
      end
      S_INIT_HOLD: begin
        w_ss_n = 1'b0;
        w_busy = 1'b1;
        if (w_gap_end)
          w_next = en ? S_WAIT : S_IDLE;
      end
      S_RD_HOLD: begin
        w_ss_n = 1'b0;
        w_busy = 1'b1;
        if (w_gap_end)
          w_next = S_UPDATE;
      end
      S_UPDATE: begin
        w_dv   = 1'b1;
        w_next = en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!en)
          w_next = S_IDLE;
        else if (w_per_end)
          w_next = S_RD_SETUP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_counting = (r_state == S_INIT_SETUP) ||
                      (r_state == S_RD_SETUP)   ||
                      (r_state == S_INIT_HOLD)  ||
                      (r_state == S_RD_HOLD)    ||
                      (r_state == S_WAIT);

  assign w_capture = (r_state == S_RD_XFER) && w_done &&
                     (r_idx >= 3'd2);

  // Sample registers load on entry to UPDATE so data and valid align
  assign w_load = (r_state == S_RD_HOLD) && w_gap_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pend      <= 1'b0;
      r_init_done <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      for (int i = 0; i < 6; i++)
        r_shadow[i] <= '0;
    end else begin
      r_state <= w_next;

      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_counting)
        r_cnt <= r_cnt + 1'b1;

      if (w_next != r_state)
        r_idx <= '0;
      else if (w_done)
        r_idx <= r_idx + 1'b1;

      if (w_start)
        r_pend <= 1'b1;
      else if (w_done)
        r_pend <= 1'b0;

      if (w_capture)
        r_shadow[r_idx - 3'd2] <= spi.spi_rd_byte;

      if (r_state == S_INIT_HOLD && w_gap_end)
        r_init_done <= 1'b1;

      if (w_load) begin
        r_x <= {r_shadow[1], r_shadow[0]};
        r_y <= {r_shadow[3], r_shadow[2]};
        r_z <= {r_shadow[5], r_shadow[4]};
      end
    end
  end

  assign spi.spi_start   = w_start;
  assign spi.spi_wr_byte = w_wr;
  assign spi.spi_ss_n    = w_ss_n;
  assign x_data          = r_x;
  assign y_data          = r_y;
  assign z_data          = r_z;
  assign data_valid      = w_dv;
  assign busy            = w_busy;
  assign init_done       = r_init_done;

endmodule

// File: tb/tb_acl_poll_ctrl.sv
// Bench for acl_poll_ctrl: SPI core model with fixed latency,
// transaction logs, and per-scenario checks.
module tb_acl_poll_ctrl;
  localparam int PER = 100;
  localparam int GAP = 4;
  localparam int LAT = 16;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        en    = 1'b0;
  logic [15:0] x_data;
  logic [15:0] y_data;
  logic [15:0] z_data;
  logic        data_valid;
  logic        busy;
  logic        init_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit         inflight = 1'b0;
  int         cd       = 0;
  int         stall    = 0;
  int         stall_at = 0;
  int         tx_n     = 0;
  int         viol     = 0;
  logic       prev_ss  = 1'b1;
  logic [7:0] last_wr  = 8'h00;
  logic [7:0] rx_cur [8];

  logic [7:0]  miso_q [$];
  logic [7:0]  wr_log [$];
  int          st_cyc [$];
  int          dn_cyc [$];
  int          fall_cyc [$];
  int          rise_cyc [$];
  int          dv_cyc [$];
  logic [15:0] dv_x [$];
  logic [15:0] dv_y [$];
  logic [15:0] dv_z [$];
  logic [15:0] ex_x [$];
  logic [15:0] ex_y [$];
  logic [15:0] ex_z [$];

  acl_poll_ctrl_if spi();

  acl_poll_ctrl #(
    .PERIOD_CYCLES(PER),
    .SS_GAP(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .spi(spi),
    .x_data(x_data),
    .y_data(y_data),
    .z_data(z_data),
    .data_valid(data_valid),
    .busy(busy),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  // ADXL362 command bytes: read-register 0x0B from 0x0E, then dummies
  function automatic logic [7:0] rd_cmd(input int i);
    if (i == 0) return 8'h0B;
    if (i == 1) return 8'h0E;
    return 8'h00;
  endfunction

  function automatic logic [7:0] init_cmd(input int i);
    if (i == 0) return 8'h0A;
    if (i == 1) return 8'h2D;
    return 8'h02;
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    st_cyc.delete();
    dn_cyc.delete();
    fall_cyc.delete();
    rise_cyc.delete();
    dv_cyc.delete();
    dv_x.delete();
    dv_y.delete();
    dv_z.delete();
    ex_x.delete();
    ex_y.delete();
    ex_z.delete();
    viol = 0;
  endtask

  task automatic load_miso();
    miso_q.delete();
    for (int i = 0; i < 8; i++)
      miso_q.push_back(8'($urandom));
  endtask

  // One clock: drive SPI core inputs, then observe the DUT
  task automatic step();
    logic [7:0] b;
    @(posedge clk);
    #1;
    cyc++;
    spi.spi_done_tick = 1'b0;
    if (inflight) begin
      cd--;
      if (cd == 0) begin
        inflight = 1'b0;
        b = (miso_q.size() > 0) ? miso_q.pop_front()
                                : 8'($urandom);
        spi.spi_done_tick = 1'b1;
        spi.spi_rd_byte   = b;
        if (tx_n >= 1 && tx_n <= 8)
          rx_cur[tx_n-1] = b;
        dn_cyc.push_back(cyc);
        if (stall_at > 0 && tx_n == stall_at) begin
          stall    = 20;
          stall_at = 0;
        end
      end
    end
    if (stall > 0) begin
      spi.spi_ready = 1'b0;
      stall--;
    end else begin
      spi.spi_ready = !inflight;
    end
    #1;
    if (spi.spi_ss_n !== prev_ss) begin
      if (spi.spi_ss_n === 1'b0) begin
        fall_cyc.push_back(cyc);
        tx_n = 0;
      end else begin
        rise_cyc.push_back(cyc);
      end
      prev_ss = spi.spi_ss_n;
    end
    if (inflight && spi.spi_wr_byte !== last_wr)
      viol++;
    if (spi.spi_start === 1'b1) begin
      if (!spi.spi_ready || inflight || spi.spi_ss_n)
        viol++;
      wr_log.push_back(spi.spi_wr_byte);
      st_cyc.push_back(cyc);
      last_wr  = spi.spi_wr_byte;
      inflight = 1'b1;
      cd       = LAT;
      tx_n++;
    end
    if (data_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_x.push_back(x_data);
      dv_y.push_back(y_data);
      dv_z.push_back(z_data);
      ex_x.push_back({rx_cur[3], rx_cur[2]});
      ex_y.push_back({rx_cur[5], rx_cur[4]});
      ex_z.push_back({rx_cur[7], rx_cur[6]});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) step();
    checks++;
    if (spi.spi_ss_n !== 1'b1) begin
      failures++;
      $display("FAIL rst_ss_n got=%b exp=1", spi.spi_ss_n);
    end
    checks++;
    if (spi.spi_start !== 1'b0 || spi.spi_wr_byte !== 8'h00) begin
      failures++;
      $display("FAIL rst_start got=%b/%h exp=0/00",
        spi.spi_start, spi.spi_wr_byte);
    end
    checks++;
    if ({x_data, y_data, z_data} !== 48'h0) begin
      failures++;
      $display("FAIL rst_xyz got=%h %h %h exp=0",
        x_data, y_data, z_data);
    end
    checks++;
    if ({data_valid, busy, init_done} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=000",
        {data_valid, busy, init_done});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_init();
    bit ok;
    clear_logs();
    en = 1'b1;
    for (int i = 0; i < 300 && init_done !== 1'b1; i++)
      step();
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_timeout got=%b exp=1", init_done);
    end
    ok = (wr_log.size() == 3);
    for (int i = 0; i < 3 && ok; i++)
      if (wr_log[i] !== init_cmd(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL init_bytes got_n=%0d exp=0A,2D,02",
        wr_log.size());
    end
    checks++;
    if (fall_cyc.size() != 1 || st_cyc.size() < 1 ||
        st_cyc[0] - fall_cyc[0] != GAP) begin
      failures++;
      $display("FAIL init_setup_gap got_falls=%0d exp=%0d cyc",
        fall_cyc.size(), GAP);
    end
    // ss_n stays low for GAP cycles after the done cycle
    checks++;
    if (rise_cyc.size() != 1 || dn_cyc.size() != 3 ||
        rise_cyc[0] - dn_cyc[2] != GAP + 1) begin
      failures++;
      $display("FAIL init_hold_gap got_rises=%0d exp=%0d",
        rise_cyc.size(), GAP + 1);
    end
    checks++;
    if (busy !== 1'b0 || spi.spi_ss_n !== 1'b1) begin
      failures++;
      $display("FAIL init_wait_idle got=%b%b exp=01",
        busy, spi.spi_ss_n);
    end
  endtask

  task automatic test_read_fixed();
    bit ok;
    clear_logs();
    miso_q.delete();
    miso_q = '{8'h11, 8'h22, 8'h34, 8'h12,
               8'h78, 8'h56, 8'hCD, 8'hAB};
    for (int i = 0; i < 600 && dv_cyc.size() < 1; i++)
      step();
    repeat (5) step();
    ok = (wr_log.size() == 8);
    for (int i = 0; i < 8 && ok; i++)
      if (wr_log[i] !== rd_cmd(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rd_bytes got_n=%0d exp=8 (0B,0E,00x6)",
        wr_log.size());
    end
    checks++;
    if (dv_cyc.size() != 1) begin
      failures++;
      $display("FAIL rd_dv_count got=%0d exp=1", dv_cyc.size());
    end else begin
      checks++;
      if ({dv_x[0], dv_y[0], dv_z[0]} !== 48'h1234_5678_ABCD) begin
        failures++;
        $display("FAIL rd_xyz got=%h %h %h exp=1234 5678 ABCD",
          dv_x[0], dv_y[0], dv_z[0]);
      end
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL rd_handshake got=%0d exp=0", viol);
    end
  endtask

  task automatic test_period();
    clear_logs();
    load_miso();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 800 && dv_cyc.size() < k + 1; i++)
        step();
      checks++;
      if (dv_cyc.size() != k + 1) begin
        failures++;
        $display("FAIL per_dv_timeout got=%0d exp=%0d",
          dv_cyc.size(), k + 1);
      end else begin
        checks++;
        if ({dv_x[k], dv_y[k], dv_z[k]} !==
            {ex_x[k], ex_y[k], ex_z[k]}) begin
          failures++;
          $display("FAIL per_xyz got=%h %h %h exp=%h %h %h",
            dv_x[k], dv_y[k], dv_z[k], ex_x[k], ex_y[k], ex_z[k]);
        end
      end
      load_miso();
      for (int i = 0; i < 300 && fall_cyc.size() < k + 2; i++)
        step();
      checks++;
      if (fall_cyc.size() != k + 2 || dv_cyc.size() != k + 1 ||
          fall_cyc[k+1] - dv_cyc[k] != PER + 1) begin
        failures++;
        $display("FAIL per_spacing got_falls=%0d exp=%0d cyc",
          fall_cyc.size(), PER + 1);
      end
    end
  endtask

  task automatic test_stall();
    clear_logs();
    load_miso();
    stall_at = 3;
    for (int i = 0; i < 800 && dv_cyc.size() < 1; i++)
      step();
    checks++;
    if (st_cyc.size() != 8 || dn_cyc.size() < 3 ||
        st_cyc[3] - dn_cyc[2] != 20) begin
      failures++;
      $display("FAIL stall_start got_starts=%0d exp=8, gap 20",
        st_cyc.size());
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL stall_handshake got=%0d exp=0", viol);
    end
    checks++;
    if (dv_cyc.size() != 1 ||
        {dv_x[0], dv_y[0], dv_z[0]} !==
        {ex_x[0], ex_y[0], ex_z[0]}) begin
      failures++;
      $display("FAIL stall_xyz got_dv=%0d exp=1 matching",
        dv_cyc.size());
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    clear_logs();
    load_miso();
    for (int i = 0; i < 800 && st_cyc.size() < 5; i++)
      step();
    en = 1'b0;
    for (int i = 0; i < 400 && dv_cyc.size() < 1; i++)
      step();
    repeat (150) step();
    checks++;
    if (wr_log.size() != 8 || dv_cyc.size() != 1) begin
      failures++;
      $display("FAIL drop_complete got=%0d/%0d exp=8/1",
        wr_log.size(), dv_cyc.size());
    end else begin
      checks++;
      if ({dv_x[0], dv_y[0], dv_z[0]} !==
          {ex_x[0], ex_y[0], ex_z[0]}) begin
        failures++;
        $display("FAIL drop_xyz got=%h %h %h exp=%h %h %h",
          dv_x[0], dv_y[0], dv_z[0], ex_x[0], ex_y[0], ex_z[0]);
      end
    end
    checks++;
    if (fall_cyc.size() != 1 || spi.spi_ss_n !== 1'b1 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got_falls=%0d ss=%b exp=1/1",
        fall_cyc.size(), spi.spi_ss_n);
    end
    clear_logs();
    load_miso();
    en = 1'b1;
    for (int i = 0; i < 400 && dv_cyc.size() < 1; i++)
      step();
    ok = (wr_log.size() == 8);
    for (int i = 0; i < 8 && ok; i++)
      if (wr_log[i] !== rd_cmd(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reen_bytes got_n=%0d exp=8 starting 0B",
        wr_log.size());
    end
    checks++;
    if (dv_cyc.size() != 1 ||
        {dv_x[0], dv_y[0], dv_z[0]} !==
        {ex_x[0], ex_y[0], ex_z[0]}) begin
      failures++;
      $display("FAIL reen_xyz got_dv=%0d exp=1 matching",
        dv_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    load_miso();
    for (int i = 0; i < 800 && st_cyc.size() < 6; i++)
      step();
    reset = 1'b1;
    step();
    checks++;
    if (spi.spi_ss_n !== 1'b1 || spi.spi_start !== 1'b0) begin
      failures++;
      $display("FAIL mrst_ss got=%b%b exp=10",
        spi.spi_ss_n, spi.spi_start);
    end
    checks++;
    if ({x_data, y_data, z_data} !== 48'h0 ||
        init_done !== 1'b0) begin
      failures++;
      $display("FAIL mrst_regs got=%h %h %h %b exp=0",
        x_data, y_data, z_data, init_done);
    end
    reset = 1'b0;
    miso_q.delete();
    clear_logs();
    for (int i = 0; i < 500 && init_done !== 1'b1; i++)
      step();
    ok = (wr_log.size() == 3) && (init_done === 1'b1);
    for (int i = 0; i < 3 && ok; i++)
      if (wr_log[i] !== init_cmd(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mrst_reinit got_n=%0d exp=3 (0A,2D,02)",
        wr_log.size());
    end
    clear_logs();
    load_miso();
    for (int i = 0; i < 800 && dv_cyc.size() < 1; i++)
      step();
    checks++;
    if (dv_cyc.size() != 1 ||
        {dv_x[0], dv_y[0], dv_z[0]} !==
        {ex_x[0], ex_y[0], ex_z[0]}) begin
      failures++;
      $display("FAIL mrst_read got_dv=%0d exp=1 matching",
        dv_cyc.size());
    end
  endtask

  initial begin
    spi.spi_ready     = 1'b1;
    spi.spi_done_tick = 1'b0;
    spi.spi_rd_byte   = 8'h00;
    test_reset();
    test_init();
    test_read_fixed();
    test_period();
    test_stall();
    test_en_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end
endmodule
